// File: rtl/palette_lut_pipeline.sv
// palette_lut_pipeline: maps (object ID, colour index) pixels to 24-bit RGB
// through a run-time writable palette store of NUM_PALETTES x 2**COLOR_WIDTH
// entries. The store is cleared to DEFAULT_COLOR after reset.
// Optional build macro PALETTE_FADE_EN adds i_fade_level and a third stage
// that scales each channel by (i_fade_level+1)/256.
`timescale 1ns/1ps

module palette_lut_pipeline #(
  parameter int          NUM_PALETTES  = 16,
  parameter int          COLOR_WIDTH   = 4,
  parameter int          ID_WIDTH      = 4,
  parameter logic [23:0] DEFAULT_COLOR = 24'hFFFFFF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pix_valid,
  output logic                   o_pix_ready,
  input  logic [ID_WIDTH-1:0]    i_object_id,
  input  logic [COLOR_WIDTH-1:0] i_encoded_color,
  output logic                   o_pix_valid,
  input  logic                   i_pix_out_ready,
  output logic [23:0]            o_decoded_color,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [ID_WIDTH-1:0]    i_wr_palette,
  input  logic [COLOR_WIDTH-1:0] i_wr_index,
  input  logic [23:0]            i_wr_data,
`ifdef PALETTE_FADE_EN
  input  logic [7:0]             i_fade_level,
`endif
  output logic                   o_busy
);

  localparam int ENTRIES = 2 ** COLOR_WIDTH;
  localparam int TOTAL   = NUM_PALETTES * ENTRIES;
  localparam int PAL_W   = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
  localparam int CNT_W   = PAL_W + COLOR_WIDTH;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [ID_WIDTH:0] PAL_LIMIT = (ID_WIDTH + 1)'(NUM_PALETTES);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] clr_cnt, clr_cnt_nxt;
  logic             init_we;

  logic                   adv;
  logic                   run;
  logic                   pix_acc;
  logic                   wr_acc;
  logic                   wr_in_range;
  logic                   rd_in_range;
  logic [ID_WIDTH-1:0]    rd_id;
  logic [COLOR_WIDTH-1:0] rd_idx;

  logic [23:0] store [NUM_PALETTES][ENTRIES];

  logic                   s1_valid;
  logic [ID_WIDTH-1:0]    s1_id;
  logic [COLOR_WIDTH-1:0] s1_idx;
  logic [23:0]            rd_data;
  logic                   s2_valid;
  logic [23:0]            s2_color;

  // State register and clear counter.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next-state logic: INIT sweeps every entry once, then RUN until reset.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    init_we     = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (clr_cnt == CNT_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign run         = (state == ST_RUN);
  assign o_busy      = (state == ST_INIT);
  assign adv         = !o_pix_valid || i_pix_out_ready;
  assign o_pix_ready = run && adv;
  assign o_wr_ready  = run;
  assign pix_acc     = i_pix_valid && o_pix_ready;
  assign wr_acc      = i_wr_valid && run;
  assign wr_in_range = ({1'b0, i_wr_palette} < PAL_LIMIT);

  // Palette store: INIT fill has priority, otherwise accepted in-range writes.
  // NOTE: the store is deliberately not reset; INIT overwrites every entry.
  always_ff @(posedge i_clk) begin
    if (init_we) begin
      store[clr_cnt[CNT_W-1:COLOR_WIDTH]][clr_cnt[COLOR_WIDTH-1:0]] <= DEFAULT_COLOR;
    end else if (wr_acc && wr_in_range) begin
      store[i_wr_palette][i_wr_index] <= i_wr_data;
    end
  end

  // Read address: the incoming pixel when the pipe advances, otherwise the
  // stalled stage-1 pixel re-reads its own entry.
  always_comb begin
    rd_id       = adv ? i_object_id     : s1_id;
    rd_idx      = adv ? i_encoded_color : s1_idx;
    rd_in_range = ({1'b0, rd_id} < PAL_LIMIT);
  end

  // Stage 1: valid, ID, index and the registered (read-before-write) lookup.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= pix_acc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (adv) begin
      s1_id  <= i_object_id;
      s1_idx <= i_encoded_color;
    end
    rd_data <= rd_in_range ? store[rd_id][rd_idx] : DEFAULT_COLOR;
  end

  // Stage 2: capture the looked-up colour alongside stage-1 valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_color <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_color <= rd_data;
    end
  end

`ifdef PALETTE_FADE_EN
  logic        s3_valid;
  logic [23:0] s3_color;

  function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [7:0] lvl);
    logic [15:0] prod;
    prod = 16'(c) * (16'(lvl) + 16'd1);
    return 8'(prod >> 8);
  endfunction

  // Stage 3: scale each channel by the fade level sampled on entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s3_valid <= 1'b0;
      s3_color <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      s3_color <= {fade_ch(s2_color[23:16], i_fade_level),
                   fade_ch(s2_color[15:8],  i_fade_level),
                   fade_ch(s2_color[7:0],   i_fade_level)};
    end
  end

  assign o_pix_valid     = s3_valid;
  assign o_decoded_color = s3_color;
`else
  assign o_pix_valid     = s2_valid;
  assign o_decoded_color = s2_color;
`endif

endmodule

// File: tb/tb_palette_lut_pipeline.sv
// Self-checking bench for palette_lut_pipeline (12 palettes so out-of-range
// IDs are reachable). A behavioural model tracks the store contents, the
// init period and the in-flight pixels; directed tests pin it with literals.
`timescale 1ns/1ps

module tb_palette_lut_pipeline;

  localparam int NP    = 12;
  localparam int ENT   = 16;
  localparam int TOTAL = NP * ENT;
  localparam logic [23:0] DEF = 24'hFFFFFF;
`ifdef PALETTE_FADE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_pix_valid = 1'b0;
  logic        o_pix_ready;
  logic [3:0]  i_object_id = '0;
  logic [3:0]  i_encoded_color = '0;
  logic        o_pix_valid;
  logic        i_pix_out_ready = 1'b1;
  logic [23:0] o_decoded_color;
  logic        i_wr_valid = 1'b0;
  logic        o_wr_ready;
  logic [3:0]  i_wr_palette = '0;
  logic [3:0]  i_wr_index = '0;
  logic [23:0] i_wr_data = '0;
  logic [7:0]  i_fade_level = 8'd255;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  palette_lut_pipeline #(
    .NUM_PALETTES (NP),
    .COLOR_WIDTH  (4),
    .ID_WIDTH     (4),
    .DEFAULT_COLOR(DEF)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pix_valid    (i_pix_valid),
    .o_pix_ready    (o_pix_ready),
    .i_object_id    (i_object_id),
    .i_encoded_color(i_encoded_color),
    .o_pix_valid    (o_pix_valid),
    .i_pix_out_ready(i_pix_out_ready),
    .o_decoded_color(o_decoded_color),
    .i_wr_valid     (i_wr_valid),
    .o_wr_ready     (o_wr_ready),
    .i_wr_palette   (i_wr_palette),
    .i_wr_index     (i_wr_index),
    .i_wr_data      (i_wr_data),
`ifdef PALETTE_FADE_EN
    .i_fade_level   (i_fade_level),
`endif
    .o_busy         (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] mm [TOTAL];
  logic        sv [LAT];
  logic [23:0] sc [LAT];
  bit          run_m   = 1'b0;
  bit          started = 1'b0;
  int          init_cnt = 0;

  function automatic logic [23:0] fade_model(input logic [23:0] c, input logic [7:0] f);
    int r, g, b;
    r = (int'(c[23:16]) * (int'(f) + 1)) / 256;
    g = (int'(c[15:8])  * (int'(f) + 1)) / 256;
    b = (int'(c[7:0])   * (int'(f) + 1)) / 256;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  function automatic logic [23:0] lookup_model(input logic [3:0] id, input logic [3:0] idx);
    if (int'(id) >= NP) return DEF;
    return mm[int'(id) * ENT + int'(idx)];
  endfunction

  // Compare process: one cycle of model and checks, sampled just before each edge.
  initial begin
    bit ready_m, adv_m;
    forever begin
      @(negedge i_clk);
      #4;
      ready_m = run_m && (!sv[LAT-1] || i_pix_out_ready);
      if (started) begin
        check("busy", o_busy, !run_m);
        check("pix_ready", o_pix_ready, ready_m);
        check("wr_ready", o_wr_ready, run_m);
        check("out_valid", o_pix_valid, sv[LAT-1]);
        if (sv[LAT-1]) check("out_color", o_decoded_color, sc[LAT-1]);
      end
      if (i_rst) begin
        started  = 1'b1;
        run_m    = 1'b0;
        init_cnt = 0;
        for (int i = 0; i < TOTAL; i++) mm[i] = DEF;
        for (int j = 0; j < LAT; j++) begin sv[j] = 1'b0; sc[j] = '0; end
      end else if (started) begin
        adv_m = !sv[LAT-1] || i_pix_out_ready;
        if (adv_m) begin
          for (int j = LAT - 1; j > 0; j--) begin
            sv[j] = sv[j-1];
            sc[j] = (LAT == 3 && j == LAT - 1) ? fade_model(sc[j-1], i_fade_level) : sc[j-1];
          end
          sv[0] = i_pix_valid && ready_m;
          sc[0] = lookup_model(i_object_id, i_encoded_color);
        end
        if (i_wr_valid && run_m && int'(i_wr_palette) < NP)
          mm[int'(i_wr_palette) * ENT + int'(i_wr_index)] = i_wr_data;
        if (!run_m) begin
          init_cnt++;
          if (init_cnt == TOTAL) run_m = 1'b1;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    int n;
    bit ready_seen;
    @(negedge i_clk);
    i_rst = 1'b1; i_pix_valid = 1'b0; i_wr_valid = 1'b0; i_pix_out_ready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    #3;
    check("rst_out_valid", o_pix_valid, 1'b0);
    check("rst_color", o_decoded_color, 24'h0);
    check("rst_busy", o_busy, 1'b1);
    check("rst_pix_ready", o_pix_ready, 1'b0);
    check("rst_wr_ready", o_wr_ready, 1'b0);
    n = 0;
    ready_seen = 1'b0;
    while (o_busy && n < 4 * TOTAL) begin
      n++;
      if (o_pix_ready || o_wr_ready) ready_seen = 1'b1;
      @(negedge i_clk);
      #3;
    end
    check("init_len", n, TOTAL);
    check("init_not_ready", ready_seen, 1'b0);
  endtask

  task automatic do_write(input logic [3:0] pal, input logic [3:0] idx, input logic [23:0] data);
    @(negedge i_clk);
    i_wr_valid = 1'b1; i_wr_palette = pal; i_wr_index = idx; i_wr_data = data;
    #3;
    check("wr_accept", o_wr_ready, 1'b1);
    @(negedge i_clk);
    i_wr_valid = 1'b0;
  endtask

  // Send one pixel into an idle pipe and require it LAT cycles later.
  task automatic pix_lat(input string nm, input logic [3:0] id, input logic [3:0] idx,
                         input logic [23:0] exp);
    @(negedge i_clk);
    i_pix_valid = 1'b1; i_object_id = id; i_encoded_color = idx;
    #3;
    check({nm, "_acc"}, o_pix_ready, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge i_clk);
      i_pix_valid = 1'b0;
      #3;
      if (k < LAT) begin
        check({nm, "_early"}, o_pix_valid, 1'b0);
      end else begin
        check({nm, "_valid"}, o_pix_valid, 1'b1);
        check({nm, "_color"}, o_decoded_color, exp);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_pix_valid = 1'b0; i_wr_valid = 1'b0; i_pix_out_ready = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [23:0] cols [8];
    logic [23:0] got  [$];
    int sent, cyc;

    do_reset();
    pix_lat("first_pix", 4'd7, 4'd9, 24'hFFFFFF);

    // Write then read back; neighbour entry keeps the init fill.
    do_write(4'd3, 4'd5, 24'h123456);
    pix_lat("wr_hit", 4'd3, 4'd5, 24'h123456);
    pix_lat("wr_neighbour", 4'd3, 4'd6, 24'hFFFFFF);

    // Out-of-range ID reads default; out-of-range write is acknowledged.
    pix_lat("id_range", 4'd15, 4'd3, DEF);
    do_write(4'd13, 4'd2, 24'h00FF00);
    pix_lat("wr_discard", 4'd13, 4'd2, DEF);

    // Collision: same-cycle write returns old value, next pixel the new one.
    @(negedge i_clk);
    i_wr_valid = 1'b1; i_wr_palette = 4'd2; i_wr_index = 4'd1; i_wr_data = 24'hABCDEF;
    i_pix_valid = 1'b1; i_object_id = 4'd2; i_encoded_color = 4'd1;
    @(negedge i_clk);
    i_wr_valid = 1'b0;
    @(negedge i_clk);
    i_pix_valid = 1'b0;
    for (int k = 2; k < LAT; k++) @(negedge i_clk);
    #3;
    check("coll_old_valid", o_pix_valid, 1'b1);
    check("coll_old", o_decoded_color, 24'hFFFFFF);
    @(negedge i_clk);
    #3;
    check("coll_new_valid", o_pix_valid, 1'b1);
    check("coll_new", o_decoded_color, 24'hABCDEF);
    idle(LAT + 1);

    // Backpressure: 8 distinct colours, downstream ready toggling 1010...
    for (int i = 0; i < 8; i++) begin
      cols[i] = 24'h010203 * 24'(i + 1);
      do_write(4'd4, 4'(i), cols[i]);
    end
    sent = 0;
    cyc  = 0;
    while (got.size() < 8 && cyc < 80) begin
      @(negedge i_clk);
      i_pix_out_ready = (cyc % 2 == 0);
      i_pix_valid     = (sent < 8);
      i_object_id     = 4'd4;
      i_encoded_color = 4'(sent);
      #3;
      if (o_pix_valid && i_pix_out_ready) got.push_back(o_decoded_color);
      if (i_pix_valid && o_pix_ready) sent++;
      cyc++;
    end
    check("bp_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) check("bp_order", got[i], cols[i]);
    idle(LAT + 1);

`ifdef PALETTE_FADE_EN
    do_write(4'd5, 4'd0, 24'hFF8040);
    i_fade_level = 8'd127;
    pix_lat("fade_127", 4'd5, 4'd0, 24'h7F4020);
    i_fade_level = 8'd255;
    pix_lat("fade_255", 4'd5, 4'd0, 24'hFF8040);
`endif

    // Random phase A: writes and pixels, downstream always ready.
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      i_pix_out_ready = 1'b1;
      i_pix_valid     = 1'($urandom_range(0, 1));
      i_object_id     = 4'($urandom_range(0, 15));
      i_encoded_color = 4'($urandom);
      i_wr_valid      = 1'($urandom_range(0, 1));
      i_wr_palette    = 4'($urandom_range(0, 15));
      i_wr_index      = 4'($urandom);
      i_wr_data       = 24'($urandom);
      i_fade_level    = 8'($urandom);
    end
    // Random phase B: random backpressure, store held constant.
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      i_wr_valid      = 1'b0;
      i_pix_out_ready = 1'($urandom_range(0, 1));
      i_pix_valid     = 1'($urandom_range(0, 1));
      i_object_id     = 4'($urandom_range(0, 15));
      i_encoded_color = 4'($urandom);
      i_fade_level    = 8'($urandom);
    end
    idle(LAT + 2);
    i_fade_level = 8'd255;

    // Reset with two pixels in flight: pipe flushes, writes are cleared.
    @(negedge i_clk);
    i_pix_valid = 1'b1; i_object_id = 4'd1; i_encoded_color = 4'd2;
    @(negedge i_clk);
    i_encoded_color = 4'd3;
    do_reset();
    pix_lat("post_rst_cleared", 4'd3, 4'd5, 24'hFFFFFF);
    pix_lat("post_rst_coll", 4'd2, 4'd1, 24'hFFFFFF);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/palette_lut_pipeline.md
Name: palette_lut_pipeline

Overview:
- Parametrised, run-time-programmable successor to the fixed-palette colour decoder.
- Maps (object ID, encoded colour index) pixel stream to 24-bit RGB through a writable palette store: NUM_PALETTES palettes × 2**COLOR_WIDTH entries.
- Sits between the frame decoder's SRAM fetch and the VGA output stage.
- Adds valid/ready backpressure, a 2-stage pipeline, self-clearing init after reset, and a palette write port for runtime recolouring (car mass level, win/lose tints).

Parameters:
NUM_PALETTES, 16, number of palettes; one per object ID 0..NUM_PALETTES-1
COLOR_WIDTH, 4, encoded colour index width; ENTRIES = 2**COLOR_WIDTH per palette
ID_WIDTH, 4, object ID width; must satisfy 2**ID_WIDTH >= NUM_PALETTES
DEFAULT_COLOR, 24'hFFFFFF, init fill value and out-of-range-ID output

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_pix_valid  in  1  input pixel valid
o_pix_ready  out  1  input pixel accepted when valid&ready
i_object_id  in  ID_WIDTH  palette select
i_encoded_color  in  COLOR_WIDTH  entry select
o_pix_valid  out  1  output pixel valid
i_pix_out_ready  in  1  downstream ready
o_decoded_color  out  24  RGB {R[23:16],G[15:8],B[7:0]}
i_wr_valid  in  1  palette write request
o_wr_ready  out  1  write accepted when valid&ready
i_wr_palette  in  ID_WIDTH  palette to write
i_wr_index  in  COLOR_WIDTH  entry to write
i_wr_data  in  24  RGB value
o_busy  out  1  high during INIT

Behaviour:
- Clock/reset: single clock i_clk; reset i_rst is synchronous, active-high.
- Reset values: o_pix_valid=0, o_decoded_color=0, o_busy=1, o_pix_ready=0, o_wr_ready=0. FSM enters INIT with clear counter at 0.
- FSM states: INIT and RUN.
- INIT:
  - Writes DEFAULT_COLOR to one palette entry per cycle, linear order: palette-major, index-minor.
  - Lasts exactly NUM_PALETTES*ENTRIES cycles, then moves to RUN. o_busy drops the same cycle RUN is entered.
  - Pixel and write ports are not ready.
- RUN: stays in RUN until reset. Reset asserted in any state (including mid-INIT or mid-stream) restarts INIT from counter 0 and flushes both pipeline stages.
- Pipeline advance: adv = !o_pix_valid | i_pix_out_ready.
- o_pix_ready = RUN & adv. This is a combinational function of i_pix_out_ready; there is no other comb path from inputs to outputs.
- Stage 1 (on adv): registers valid, ID and index.
- Stage 2 (on adv): registers the looked-up colour and stage-1 valid into o_pix_valid/o_decoded_color.
- Latency: 2 cycles from accept to o_pix_valid, with no stall. Throughput 1 pixel/cycle.
- Stall: while o_pix_valid & !i_pix_out_ready, both stages and o_decoded_color hold. No pixel is lost or duplicated.
- Out-of-range ID: i_object_id >= NUM_PALETTES outputs DEFAULT_COLOR. The store is not accessed.
- Writes:
  - o_wr_ready = RUN (independent of pixel stall).
  - Entry updates at the accepting edge.
  - A write with i_wr_palette >= NUM_PALETTES is acknowledged and discarded.
- Read/write collision: a stage-1 lookup of an entry written in the same cycle returns the old value (read-before-write). The next lookup returns the new value.
- Stalled lookup: a stalled stage-1 pixel re-reads the store each cycle. The value captured is the one present on the advancing edge.
- Store may be flops or inferred RAM with a registered read, provided the timing above is met.

Optional Feature:
- Macro: PALETTE_FADE_EN.
- When defined:
  - Adds input i_fade_level (8 bits) and a third pipeline stage after lookup.
  - Each channel becomes (c*(i_fade_level+1))>>8. i_fade_level=255 is identity; 0 gives (c*1)>>8, i.e. 0 for every c <= 255.
  - i_fade_level is sampled when the pixel enters stage 3.
  - Latency is 3 cycles. Stall and reset rules extend to stage 3. o_pix_ready uses the stage-3 valid in adv.
- When undefined: no i_fade_level port, latency 2, no multipliers.

Test Plan:
- Init: reset 1 cycle (defaults 16×16) -> o_busy high and o_pix_ready low for exactly 256 cycles; first pixel (ID 7, idx 9) afterwards -> o_decoded_color=24'hFFFFFF, 2 cycles after accept.
- Write/read: write palette 3 idx 5 = 24'h123456, then pixel (3,5) -> 24'h123456 at latency 2. Pixel (3,6) -> 24'hFFFFFF.
- Backpressure: stream 8 pixels with distinct written colours, i_pix_out_ready toggling 1010... -> all 8 colours out in order, none dropped or duplicated. Output held stable while stalled.
- Collision: write (2,1)=24'hABCDEF in the same cycle pixel (2,1) is accepted -> old 24'hFFFFFF. Pixel (2,1) next cycle -> 24'hABCDEF.
- Range/reset: pixel ID 15 with NUM_PALETTES=12 -> DEFAULT_COLOR. Reset asserted mid-stream with 2 pixels in flight -> o_pix_valid=0 next cycle, INIT restarts, earlier writes cleared to FFFFFF.
- PALETTE_FADE_EN: entry 24'hFF8040, i_fade_level=127 -> 24'h7F4020 at latency 3. i_fade_level=255 -> 24'hFF8040.
